// File: rtl/nn_layer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_layer_pkg
//  Brief    : Shared constants and FSM encoding for the layer MAC scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package nn_layer_pkg;

    localparam int          c_N_IN       = 15;
    localparam int          c_N_NODE_MAX = 8;
    localparam int          c_FRAC       = 13;
    localparam logic [3:0]  c_BIAS_IDX   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nn_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module   : nn_mac_unit
//  Brief    : Single shared 32x32 multiply-accumulate with ReLU/quantise.
//  Revision : 1.0  initial release
// ============================================================================
module nn_mac_unit #(
    parameter int FRAC = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_accum,
    input  logic [31:0] i_act,
    input  logic [31:0] i_w,
    output logic [31:0] o_q_next
);

    logic [31:0] r_acc;
    logic [31:0] w_prod;
    logic [31:0] w_acc_next;

    // Low 32 bits of the product are identical for signed and unsigned operands.
    always_comb begin
        w_prod     = i_act * i_w;
        w_acc_next = r_acc;
        if (i_load)
            w_acc_next = i_w;
        else if (i_accum)
            w_acc_next = r_acc + w_prod;
        o_q_next = w_acc_next[31] ? 32'd0 : {16'd0, w_acc_next[FRAC+15:FRAC]};
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_acc <= 32'd0;
        else
            r_acc <= w_acc_next;
    end

endmodule
`default_nettype wire

// File: rtl/layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : layer_mac_scheduler
//  Brief    : Sequences bias + N_IN weighted inputs per node through one MAC.
//  Revision : 1.0  initial release
// ============================================================================
module layer_mac_scheduler
    import nn_layer_pkg::*;
#(
    parameter int N_IN       = c_N_IN,
    parameter int N_NODE_MAX = c_N_NODE_MAX,
    parameter int FRAC       = c_FRAC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  n_nodes,
    output logic        busy,
    output logic        done,
    output logic [3:0]  act_addr,
    input  logic [31:0] act_data,
    output logic [6:0]  w_addr,
    input  logic [31:0] w_data,
    output logic        out_valid,
    output logic [2:0]  out_idx,
    output logic [31:0] out_data
);

    localparam logic [4:0] c_C_LAST = 5'(N_IN);
    localparam logic [3:0] c_N_MAX  = 4'(N_NODE_MAX);

    state_t      r_state;
    logic [3:0]  r_node;
    logic [3:0]  r_n_lat;
    logic [4:0]  r_c;
    logic        r_ph_valid;
    logic        r_ph_bias;
    logic [3:0]  w_n_clamped;
    logic [31:0] w_q_next;
    logic        w_load;
    logic        w_accum;

    always_comb begin
        w_n_clamped = (n_nodes > c_N_MAX) ? c_N_MAX : n_nodes;
        w_load      = r_ph_valid & r_ph_bias;
        w_accum     = r_ph_valid & ~r_ph_bias;
    end

    nn_mac_unit #(.FRAC(FRAC)) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_accum  (w_accum),
        .i_act    (act_data),
        .i_w      (w_data),
        .o_q_next (w_q_next)
    );

    // r_ph_* track which issue slot the read data arriving this cycle belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_node     <= 4'd0;
            r_n_lat    <= 4'd0;
            r_c        <= 5'd0;
            r_ph_valid <= 1'b0;
            r_ph_bias  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_idx    <= 3'd0;
            out_data   <= 32'd0;
            act_addr   <= 4'd0;
            w_addr     <= 7'd0;
        end else begin
            done       <= 1'b0;
            out_valid  <= 1'b0;
            r_ph_valid <= 1'b0;
            r_ph_bias  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        r_n_lat <= w_n_clamped;
                        r_node  <= 4'd0;
                        r_c     <= 5'd0;
                        if (w_n_clamped == 4'd0) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state  <= ST_ISSUE;
                            w_addr   <= {3'd0, c_BIAS_IDX};
                            act_addr <= 4'd0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_ph_valid <= 1'b1;
                    r_ph_bias  <= (r_c == 5'd0);
                    if (r_c == c_C_LAST) begin
                        r_state  <= ST_DRAIN;
                        r_c      <= 5'd0;
                        w_addr   <= 7'd0;
                        act_addr <= 4'd0;
                    end else begin
                        r_c      <= r_c + 5'd1;
                        w_addr   <= {r_node[2:0], r_c[3:0]};
                        act_addr <= r_c[3:0];
                    end
                end
                ST_DRAIN: begin
                    r_state   <= ST_EMIT;
                    out_valid <= 1'b1;
                    out_idx   <= r_node[2:0];
                    out_data  <= w_q_next;
                end
                ST_EMIT: begin
                    if ((r_node + 4'd1) < r_n_lat) begin
                        r_node  <= r_node + 4'd1;
                        r_c     <= 5'd0;
                        r_state <= ST_ISSUE;
                        w_addr  <= {r_node[2:0] + 3'd1, c_BIAS_IDX};
                    end else begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_mac_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_mac_scheduler
//  Brief    : Self-checking bench with memory models and a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_mac_scheduler;

    localparam int c_N_IN  = 15;
    localparam int c_NODE_LAT = c_N_IN + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  n_nodes = 4'd0;
    logic        busy, done, out_valid;
    logic [3:0]  act_addr;
    logic [6:0]  w_addr;
    logic [31:0] act_data = 32'd0;
    logic [31:0] w_data = 32'd0;
    logic [2:0]  out_idx;
    logic [31:0] out_data;

    logic [31:0] act_mem [16];
    logic [31:0] w_mem   [128];

    logic [34:0] exp_q [$];
    logic [34:0] obs_q [$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int addr_viol = 0;

    layer_mac_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_nodes   (n_nodes),
        .busy      (busy),
        .done      (done),
        .act_addr  (act_addr),
        .act_data  (act_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffers: data appears one cycle after the address.
    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid) obs_q.push_back({out_idx, out_data});
        if (!busy && (act_addr != 4'd0 || w_addr != 7'd0)) addr_viol++;
    end

    function automatic logic [31:0] model_node(input int nd);
        logic [31:0] acc;
        logic [63:0] p;
        acc = w_mem[nd*16 + 15];
        for (int k = 0; k < c_N_IN; k++) begin
            p   = act_mem[k] * w_mem[nd*16 + k];
            acc = acc + p[31:0];
        end
        return acc[31] ? 32'd0 : ((acc >> 13) & 32'h0000_FFFF);
    endfunction

    task automatic fill_const(input logic [31:0] a, input logic [31:0] w, input logic [31:0] b);
        for (int i = 0; i < 16; i++) act_mem[i] = a;
        for (int i = 0; i < 128; i++) w_mem[i] = ((i % 16) == 15) ? b : w;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) act_mem[i] = $urandom_range(0, 16384) - 32'd4096;
        for (int i = 0; i < 128; i++) w_mem[i] = $urandom_range(0, 4096) - 32'd2048;
    endtask

    task automatic push_exp(input int n);
        for (int nd = 0; nd < n; nd++) exp_q.push_back({3'(nd), model_node(nd)});
    endtask

    // Drives one pass and waits for done; optionally keeps start/n_nodes toggling.
    task automatic do_pass(input logic [3:0] n, input bit spam, output int lat, output bit timed_out);
        int s, d0, budget;
        @(negedge clk);
        obs_q.delete();
        busy_cnt = 0;
        d0 = done_cnt;
        s = cyc;
        start = 1'b1;
        n_nodes = n;
        budget = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (done_cnt != d0) break;
            budget++;
            if (budget > 2000) begin
                timed_out = 1'b1;
                break;
            end
            if (spam) begin
                start = 1'b1;
                n_nodes = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_nodes = 4'd0;
        lat = done_cyc - s;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if ({out_idx, out_data} !== 35'd0) begin errors++; $display("FAIL reset_out: got %0d/%0d want 0/0", out_idx, out_data); end
        checks++; if ({act_addr, w_addr} !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", act_addr, w_addr); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int lat; bit to;
        logic [34:0] o;
        fill_const(32'd8192, 32'd1024, 32'd8192);
        exp_q.push_back({3'd0, 32'd15361});
        do_pass(4'd1, 1'b0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: got %0b want 0", to); end
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== exp_q[0]) begin errors++; $display("FAIL single_data: got %0d/%0d want %0d/%0d", o[34:32], o[31:0], exp_q[0][34:32], exp_q[0][31:0]); end
            void'(exp_q.pop_front());
        end
        checks++; if (lat !== c_NODE_LAT + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, c_NODE_LAT + 2); end
        checks++; if (busy_cnt !== c_NODE_LAT + 1) begin errors++; $display("FAIL single_busy: got %0d want %0d", busy_cnt, c_NODE_LAT + 1); end
        exp_q.delete();
    endtask

    task automatic test_two_nodes();
        int lat; bit to;
        logic [34:0] o;
        fill_const(32'd8192, 32'd1024, 32'd8192);
        for (int k = 0; k < 15; k++) w_mem[16 + k] = -32'sd1024;
        exp_q.push_back({3'd0, 32'd15361});
        exp_q.push_back({3'd1, 32'd0});
        do_pass(4'd2, 1'b0, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL two_timeout: got %0b want 0", to); end
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL two_count: got %0d want 2", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== exp_q[0]) begin errors++; $display("FAIL two_data: got %0d/%0d want %0d/%0d", o[34:32], o[31:0], exp_q[0][34:32], exp_q[0][31:0]); end
            void'(exp_q.pop_front());
        end
        checks++; if (lat !== 2*c_NODE_LAT + 2) begin errors++; $display("FAIL two_latency: got %0d want %0d", lat, 2*c_NODE_LAT + 2); end
        exp_q.delete();
    endtask

    task automatic test_truncate();
        int lat; bit to;
        logic [34:0] o;
        fill_const(32'd8192, 32'd0, 32'h2000_0000);
        do_pass(4'd1, 1'b0, lat, to);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL trunc_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== 35'd0) begin errors++; $display("FAIL trunc_data: got %0d/%0d want 0/0", o[34:32], o[31:0]); end
        end
    endtask

    task automatic test_zero_nodes();
        int lat; bit to;
        int d0;
        d0 = done_cnt;
        do_pass(4'd0, 1'b0, lat, to);
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL zero_outputs: got %0d want 0", obs_q.size()); end
        checks++; if (busy_cnt !== 1) begin errors++; $display("FAIL zero_busy: got %0d want 1", busy_cnt); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_clamp_random();
        int lat; bit to;
        logic [34:0] o;
        fill_rand();
        push_exp(8);
        do_pass(4'd13, 1'b0, lat, to);
        checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL clamp_count: got %0d want 8", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== exp_q[0]) begin errors++; $display("FAIL clamp_data: got %0d/%0d want %0d/%0d", o[34:32], o[31:0], exp_q[0][34:32], exp_q[0][31:0]); end
            void'(exp_q.pop_front());
        end
        checks++; if (lat !== 8*c_NODE_LAT + 2) begin errors++; $display("FAIL clamp_latency: got %0d want %0d", lat, 8*c_NODE_LAT + 2); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int d0, budget, lat;
        bit to;
        logic [34:0] o;
        fill_rand();
        push_exp(3);
        @(negedge clk);
        obs_q.delete();
        d0 = done_cnt;
        start = 1'b1;
        n_nodes = 4'd8;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (obs_q.size() < 3 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        checks++; if (budget >= 500) begin errors++; $display("FAIL mid_wait: got timeout want 3 results"); end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, out_valid} !== 3'b000) begin errors++; $display("FAIL mid_flags: got %b want 000", {busy, done, out_valid}); end
        checks++; if ({out_idx, out_data} !== 35'd0) begin errors++; $display("FAIL mid_out: got %0d/%0d want 0/0", out_idx, out_data); end
        checks++; if ({act_addr, w_addr} !== 11'd0) begin errors++; $display("FAIL mid_addr: got %0d/%0d want 0/0", act_addr, w_addr); end
        reset = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); end
        checks++; if (obs_q.size() !== 3) begin errors++; $display("FAIL mid_count: got %0d want 3", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== exp_q[0]) begin errors++; $display("FAIL mid_data: got %0d/%0d want %0d/%0d", o[34:32], o[31:0], exp_q[0][34:32], exp_q[0][31:0]); end
            void'(exp_q.pop_front());
        end
        exp_q.delete();
        push_exp(2);
        do_pass(4'd2, 1'b0, lat, to);
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL restart_count: got %0d want 2", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== exp_q[0]) begin errors++; $display("FAIL restart_data: got %0d/%0d want %0d/%0d", o[34:32], o[31:0], exp_q[0][34:32], exp_q[0][31:0]); end
            void'(exp_q.pop_front());
        end
        checks++; if (lat !== 2*c_NODE_LAT + 2) begin errors++; $display("FAIL restart_latency: got %0d want %0d", lat, 2*c_NODE_LAT + 2); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int lat, d0;
        bit to;
        logic [34:0] o;
        fill_rand();
        push_exp(4);
        d0 = done_cnt;
        do_pass(4'd4, 1'b1, lat, to);
        repeat (40) @(negedge clk);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_timeout: got %0b want 0", to); end
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o !== exp_q[0]) begin errors++; $display("FAIL b2b_data: got %0d/%0d want %0d/%0d", o[34:32], o[31:0], exp_q[0][34:32], exp_q[0][31:0]); end
            void'(exp_q.pop_front());
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", done_cnt - d0); end
        checks++; if (lat !== 4*c_NODE_LAT + 2) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, 4*c_NODE_LAT + 2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b want 0", busy); end
        exp_q.delete();
    endtask

    initial begin
        fill_const(32'd0, 32'd0, 32'd0);
        test_reset();
        test_single();
        test_two_nodes();
        test_truncate();
        test_zero_nodes();
        test_clamp_random();
        test_reset_mid();
        test_back_to_back();
        checks++; if (addr_viol !== 0) begin errors++; $display("FAIL idle_addr: got %0d nonzero idle cycles want 0", addr_viol); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_mac_scheduler.md
LAYER_MAC_SCHEDULER -- requirements
Module: layer_mac_scheduler

Interface
REQ-001 Parameter N_IN, default 15, inputs per node (max 15).
REQ-002 Parameter N_NODE_MAX, default 8, maximum nodes per layer pass.
REQ-003 Parameter FRAC, default 13, fixed-point fraction bits of activations and weights.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 start  input  1  begin a layer pass; sampled only in IDLE.
REQ-007 n_nodes  input  4  node count for the pass, latched when start is accepted.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse at end of pass.
REQ-010 act_addr  output  4  activation buffer read address.
REQ-011 act_data  input  32  activation read data, valid one cycle after act_addr.
REQ-012 w_addr  output  7  weight ROM address {node[2:0], idx[3:0]}; idx 15 holds the bias.
REQ-013 w_data  input  32  weight/bias read data, valid one cycle after w_addr.
REQ-014 out_valid  output  1  one-cycle strobe, result on out_idx/out_data.
REQ-015 out_idx  output  3  node index of the result.
REQ-016 out_data  output  32  ReLU-quantised node result.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN, EMIT, FIN.
REQ-018 IDLE -> ISSUE on start=1 with n_nodes in 1..N_NODE_MAX; node counter=0, issue counter c=0.
REQ-019 start=1 with n_nodes=0 SHALL go IDLE -> FIN; done pulses exactly 2 cycles after start; no out_valid.
REQ-020 n_nodes > N_NODE_MAX SHALL be clamped to N_NODE_MAX.
REQ-021 ISSUE lasts 1+N_IN cycles: c=0 drives w_addr={node,15} (bias); c=k (1..N_IN) drives w_addr={node,k-1}, act_addr=k-1.
REQ-022 Data returned for c=0 SHALL load acc := w_data; data for c=k SHALL do acc := acc + act_data*w_data, product and sum truncated to 32 bits, two's complement, no saturation.
REQ-023 ISSUE -> DRAIN after c=N_IN; DRAIN (1 cycle) absorbs the final returned data.
REQ-024 EMIT (1 cycle): out_valid=1, out_idx=node, out_data = acc[31]==0 ? zero-extended acc[FRAC+15:FRAC] : 0.
REQ-025 EMIT -> ISSUE (node+1, c=0) if node+1 < latched n_nodes, else -> FIN.
REQ-026 FIN (1 cycle): done=1, busy=0 the following cycle; -> IDLE.
REQ-027 Per-node latency SHALL be N_IN+3 cycles; a pass takes n_nodes*(N_IN+3)+1 cycles from start-accept to done.
REQ-028 start while not IDLE SHALL be ignored; n_nodes changes mid-pass SHALL have no effect.
REQ-029 act_addr/w_addr SHALL hold 0 outside ISSUE.
REQ-030 Multiplier usage SHALL be one 32x32 product per cycle (single shared MAC).

Reset
REQ-031 On reset=0 at a clock edge: state IDLE, busy=0, done=0, out_valid=0, out_idx=0, out_data=0, act_addr=0, w_addr=0, acc=0, counters=0.
REQ-032 Reset mid-pass SHALL abort immediately without emitting done or further out_valid.

Structure
REQ-033 State encoding, N_IN/N_NODE_MAX/FRAC defaults and the bias index (15) SHALL live in shared package nn_layer_pkg.
REQ-034 The multiply-accumulate with ReLU/quantise SHALL be one sub-module, nn_mac_unit; FSM and addressing stay in the top.

Verification
REQ-035 All act=8192, all weights=1024, bias=8192, n_nodes=1 -> one out_valid, out_idx=0, out_data=15361 (0x3C01), done 19 cycles after start.
REQ-036 Same data, weights=-1024 for node 1, n_nodes=2 -> node0 out_data=15361, node1 out_data=0; done after 37 cycles.
REQ-037 Bias=0x20000000, weights=0 -> out_data=0 (bit 29 dropped by truncation, bit 31 clear).
REQ-038 n_nodes=0 -> done pulse 2 cycles after start, no out_valid, busy high 1 cycle.
REQ-039 reset=0 during node 3 ISSUE of n_nodes=8 -> all outputs 0 next cycle, no done; new start then completes normally.
REQ-040 start re-asserted every cycle during a pass with n_nodes=4 -> exactly 4 out_valid, single done, no restart.
